// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the execute-stage memory wrapper and data memory.
// Both channels use valid/ready handshakes; the initiator is the master and the responder is the slave.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, response LATENCY+1 cycles after accept (errors: 1).
// Backpressure: a response is held stable until taken; no new request is accepted until then.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;

  logic            lat_we;
  logic [2:0]      lat_size;
  logic [AW-1:0]   lat_idx;
  logic [1:0]      lat_off;
  logic [31:0]     lat_wdata;

  logic            in_idle;
  logic            accept;
  logic            req_bad;
  logic            lat_en;
  logic            acc_en;
  logic            err_set;
  logic            rsp_clr;

  logic            a_we;
  logic [2:0]      a_size;
  logic [AW-1:0]   a_idx;
  logic [1:0]      a_off;
  logic [31:0]     a_wdata;
  logic [3:0]      a_be;
  logic [31:0]     a_wlane;
  logic [31:0]     a_word;
  logic [7:0]      a_byte;
  logic [15:0]     a_half;
  logic [31:0]     a_load;

  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [31:0]     mem [DEPTH];
  logic            unused_addr_bits;

  assign in_idle          = (state == IDLE);
  assign accept           = bus.req_valid && bus.req_ready;
  assign unused_addr_bits = ^bus.req_addr[31:AW+2];

  // Size/alignment legality of the request on the bus; only meaningful while idle.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      3'd0:    req_bad = 1'b0;
      3'd1:    req_bad = bus.req_addr[0];
      3'd2:    req_bad = |bus.req_addr[1:0];
      3'd4:    req_bad = bus.req_we;
      3'd5:    req_bad = bus.req_we | bus.req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_en    = 1'b0;
    acc_en    = 1'b0;
    err_set   = 1'b0;
    rsp_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lat_en = 1'b1;
          if (req_bad) begin
            err_set   = 1'b1;
            state_nxt = RESP;
          end else if (LATENCY == 0) begin
            acc_en    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = 4'(LATENCY);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          acc_en    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (lat_en) begin
      lat_we    <= bus.req_we;
      lat_size  <= bus.req_size;
      lat_idx   <= bus.req_addr[AW+1:2];
      lat_off   <= bus.req_addr[1:0];
      lat_wdata <= bus.req_wdata;
    end
  end

  // A zero-latency access happens on the accept edge, so it must see the live bus fields.
  assign a_we    = in_idle ? bus.req_we             : lat_we;
  assign a_size  = in_idle ? bus.req_size           : lat_size;
  assign a_idx   = in_idle ? bus.req_addr[AW+1:2]   : lat_idx;
  assign a_off   = in_idle ? bus.req_addr[1:0]      : lat_off;
  assign a_wdata = in_idle ? bus.req_wdata          : lat_wdata;

  always_comb begin
    a_be    = 4'b1111;
    a_wlane = a_wdata;
    case (a_size[1:0])
      2'd0: begin
        a_be    = 4'b0001 << a_off;
        a_wlane = {4{a_wdata[7:0]}};
      end
      2'd1: begin
        a_be    = a_off[1] ? 4'b1100 : 4'b0011;
        a_wlane = {2{a_wdata[15:0]}};
      end
      default: begin
        a_be    = 4'b1111;
        a_wlane = a_wdata;
      end
    endcase
  end

  assign a_word = mem[a_idx];

  always_comb begin
    a_byte = a_word[8*a_off +: 8];
    a_half = a_off[1] ? a_word[31:16] : a_word[15:0];
    case (a_size[1:0])
      2'd0:    a_load = {{24{a_byte[7] & ~a_size[2]}}, a_byte};
      2'd1:    a_load = {{16{a_half[15] & ~a_size[2]}}, a_half};
      default: a_load = a_word;
    endcase
  end

  // Reset takes priority so an access due on a reset edge is abandoned.
  always_ff @(posedge clk) begin
    if (acc_en && a_we && !rst) begin
      if (a_be[0]) mem[a_idx][7:0]   <= a_wlane[7:0];
      if (a_be[1]) mem[a_idx][15:8]  <= a_wlane[15:8];
      if (a_be[2]) mem[a_idx][23:16] <= a_wlane[23:16];
      if (a_be[3]) mem[a_idx][31:24] <= a_wlane[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rsp_clr) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (err_set) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b1;
    end else if (acc_en) begin
      rsp_rdata_q <= a_we ? 32'd0 : a_load;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.req_ready = in_idle && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  rsp_hold_a: assert property (@(posedge clk) disable iff (rst)
    bus.rsp_valid && !bus.rsp_ready |=>
      bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err));

  err_zero_a: assert property (@(posedge clk) disable iff (rst)
    bus.rsp_err |-> (bus.rsp_rdata == 32'd0));

endmodule
